dff7474_ctrl: RTL and testbench
===============================

Name: dff7474_ctrl

Overview:
- Sequencer and arbiter that shares one SN7474 dual D flip-flop chip between two requesters.
- Converts each granted request (load, preset, clear, read on FF1 or FF2) into correctly timed pin waveforms: D setup, clock or async pulse, hold.
- Samples Q/Qn after each operation and returns a one-cycle response.
- Sits between the bus-side logic and the chip-level TTL model in board-level testbenches.

Parameters:
- SETUP_CYC, 2, cycles D is held stable before the clock or async pulse (>=1).
- PULSE_CYC, 2, cycles the clock is high, or PRE_n/CLR_n is low (>=1).
- HOLD_CYC, 1, cycles D is held after the pulse ends (>=1).
- CNT_W, 8, phase counter width; every *_CYC must be <= 2^CNT_W-1.

Ports:
- clk in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high.
- req0_valid in 1, req0_op in 2, req0_sel in 1 (0=FF1, 1=FF2), req0_d in 1, req0_ready out 1.
- req1_valid, req1_op, req1_sel, req1_d in; req1_ready out: same widths and meaning as requester 0.
- rsp_valid out 1, rsp_id out 1 (requester index), rsp_q out 1, rsp_err out 1.
- ff1_clr_n out 1 (P1), ff1_d out 1 (P2), ff1_clk out 1 (P3), ff1_pre_n out 1 (P4).
- ff2_pre_n out 1 (P10), ff2_clk out 1 (P11), ff2_d out 1 (P12), ff2_clr_n out 1 (P13).
- q1 in 1 (P5), q1_n in 1 (P6), q2_n in 1 (P8), q2 in 1 (P9).

Behaviour:
- Op encoding: 00 LOAD, 01 PRESET, 10 CLEAR, 11 READ.
- Reset value of all outputs: ff*_clk=0, ff*_pre_n=1, ff*_clr_n=1, ff*_d=0, req*_ready=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_err=0. Internal last_grant=1, so req0 wins first.
- Idle pin levels are the same as the reset levels. Only the selected FF's pins ever move.
- FSM states: IDLE, SETUP, PULSE, HOLD, SAMPLE, RESP.
- IDLE: round-robin grant among valid requesters; with both valid, the one not last granted wins.
  - reqN_ready=1 combinationally only in IDLE, only for the granted requester.
  - On the accept edge, latch op/sel/d/id, update last_grant, and go to SETUP (READ goes straight to SAMPLE).
- SETUP: drive selected D=latched d (LOAD only; other ops keep D=0) for SETUP_CYC cycles.
- PULSE, PULSE_CYC cycles:
  - LOAD: clk=1.
  - PRESET: pre_n=0.
  - CLEAR: clr_n=0.
  - Pins return to idle level on the edge leaving PULSE.
- HOLD: D unchanged for HOLD_CYC cycles, then D=0 on exit.
- SAMPLE: one cycle; register q and q_n of the selected FF.
- RESP: rsp_valid=1 for exactly one cycle with rsp_id, rsp_q, rsp_err; no backpressure. Next state IDLE.
- Latency from accept edge to rsp_valid cycle: SETUP_CYC+PULSE_CYC+HOLD_CYC+2 (defaults: 7). READ: 2.
- Requests arriving while busy are held off (ready=0) and not lost; requesters must keep valid/op/sel/d stable until accepted.
- Throughput: at most one operation in flight; the next accept can occur the cycle after RESP.
- Reset mid-operation: FSM goes to IDLE immediately, pins return to idle levels asynchronously, no response is issued.
- Phase counter counts down from *_CYC-1 to 0; no wrap is possible given the parameter constraint.

Optional Feature:
- Macro: DFF7474_ERR_CHECK_EN.
- Defined: rsp_err=1 if the sampled q==q_n, or if q differs from the expected value (LOAD: d; PRESET: 1; CLEAR: 0; READ: only the q==q_n check).
- Undefined: rsp_err tied to 0 and the compare logic is not synthesised.

Decomposition:
- Package dff7474_pkg holds:
  - op codes OP_LOAD, OP_PRESET, OP_CLEAR, OP_READ;
  - state encodings S_IDLE..S_RESP;
  - pin idle-level constants.
- One sub-module: rr_arb2, a two-input round-robin arbiter with last_grant state, instantiated once.

Test Plan:
1. req0 LOAD sel=0 d=1 with defaults -> ff1_clk high 2 cycles starting 2 cycles after accept; rsp_valid 7 cycles after accept, rsp_id=0, rsp_q=1, rsp_err=0.
2. req0 and req1 both valid after reset -> req0 accepted first, req1 next; with both held valid, grants alternate 0,1,0,1.
3. req1 CLEAR sel=1 after LOAD d=1 -> ff2_clr_n low 2 cycles; rsp_q=0; ff2 D stays 0 throughout.
4. READ sel=0 -> no pin activity; rsp_valid 2 cycles after accept, rsp_q equals the current q1.
5. reset asserted during PULSE of a LOAD -> ff1_clk=0 and all pins idle the same cycle; no rsp_valid; next request proceeds normally.
6. With DFF7474_ERR_CHECK_EN, force q1=q1_n=1 during PRESET -> rsp_err=1; without the macro -> rsp_err=0.

Source files
------------

// File: rtl/dff7474_pkg.sv
// dff7474_pkg: op codes, FSM state encodings and SN7474 pin idle levels
// shared by the dff7474_ctrl sequencer, its bus interface and bench.
package dff7474_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_PRESET = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_READ   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_SAMPLE,
    S_RESP
  } state_e;

  localparam logic CLK_IDLE   = 1'b0;
  localparam logic D_IDLE     = 1'b0;
  localparam logic PRE_N_IDLE = 1'b1;
  localparam logic CLR_N_IDLE = 1'b1;

  // Q the chip should show after a completed op (READ has none).
  function automatic logic exp_q(op_e op, logic d);
    logic q;
    q = 1'b0;
    unique case (1'b1)
      op == OP_LOAD:   q = d;
      op == OP_PRESET: q = 1'b1;
      default:         q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/dff7474_ctrl_if.sv
// dff7474_ctrl_if: two requester valid/ready channels plus the shared
// one-cycle response. master = bus side, slave = dff7474_ctrl.
interface dff7474_ctrl_if;
  import dff7474_pkg::*;

  logic req0_valid;
  op_e  req0_op;
  logic req0_sel;
  logic req0_d;
  logic req0_ready;

  logic req1_valid;
  op_e  req1_op;
  logic req1_sel;
  logic req1_d;
  logic req1_ready;

  logic rsp_valid;
  logic rsp_id;
  logic rsp_q;
  logic rsp_err;

  modport master (
    output req0_valid, req0_op, req0_sel, req0_d,
    output req1_valid, req1_op, req1_sel, req1_d,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_q, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_sel, req0_d,
    input  req1_valid, req1_op, req1_sel, req1_d,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_q, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter. Ports: clk, reset, en (offer
// grants), req[1:0], gnt[1:0] one-hot, id = index of the winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       id
);

  logic last;

  // On a tie the requester not served last wins.
  assign id  = (req[0] && req[1]) ? ~last : req[1];
  assign gnt = {en & req[1] & id, en & req[0] & ~id};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= id;
    end
  end

endmodule

// File: rtl/dff7474_ctrl.sv
// dff7474_ctrl: shares one SN7474 between two requesters; ports clk, reset,
// bus (dff7474_ctrl_if.slave), ff1/ff2 pin outputs and q1/q1_n/q2/q2_n.
// Optional DFF7474_ERR_CHECK_EN adds the Q/Qn consistency check on rsp_err.
module dff7474_ctrl
  import dff7474_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  dff7474_ctrl_if.slave      bus,
  output logic               ff1_clr_n,
  output logic               ff1_d,
  output logic               ff1_clk,
  output logic               ff1_pre_n,
  output logic               ff2_pre_n,
  output logic               ff2_clk,
  output logic               ff2_d,
  output logic               ff2_clr_n,
  input  logic               q1,
  input  logic               q1_n,
  input  logic               q2_n,
  input  logic               q2
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_e           st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [1:0] gnt;
  logic       gid;
  logic       acc;
  op_e        acc_op;

  op_e  op_q;
  logic sel_q, d_q, id_q;
  logic q_s, err;
  logic rsp_v, rsp_id_q, rsp_q_q, rsp_err_q;

  // Grants are withheld while reset is held so ready reads 0.
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (st == S_IDLE && !reset),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .gnt   (gnt),
    .id    (gid)
  );

  assign acc            = |gnt;
  assign acc_op         = gid ? bus.req1_op : bus.req0_op;
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    unique case (st)
      S_IDLE: begin
        if (acc) begin
          if (acc_op == OP_READ) begin
            st_nxt = S_SAMPLE;
          end else begin
            st_nxt  = S_SETUP;
            cnt_nxt = SETUP_LD;
          end
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          st_nxt  = S_PULSE;
          cnt_nxt = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          st_nxt  = S_HOLD;
          cnt_nxt = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          st_nxt = S_SAMPLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_SAMPLE: st_nxt = S_RESP;
      S_RESP:   st_nxt = S_IDLE;
      default:  st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= S_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // The response register loads as the FSM leaves RESP, so rsp_valid
  // shows in the following cycle, alongside the next possible grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_LOAD;
      sel_q     <= 1'b0;
      d_q       <= 1'b0;
      id_q      <= 1'b0;
      q_s       <= 1'b0;
      rsp_v     <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_q_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (acc) begin
        op_q  <= acc_op;
        sel_q <= gid ? bus.req1_sel : bus.req0_sel;
        d_q   <= gid ? bus.req1_d : bus.req0_d;
        id_q  <= gid;
      end
      if (st == S_SAMPLE) begin
        q_s <= sel_q ? q2 : q1;
      end
      rsp_v <= (st == S_RESP);
      if (st == S_RESP) begin
        rsp_id_q  <= id_q;
        rsp_q_q   <= q_s;
        rsp_err_q <= err;
      end
    end
  end

`ifdef DFF7474_ERR_CHECK_EN
  logic qn_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qn_s <= 1'b0;
    end else if (st == S_SAMPLE) begin
      qn_s <= sel_q ? q2_n : q1_n;
    end
  end

  assign err = (q_s == qn_s) ||
               (op_q != OP_READ && q_s != exp_q(op_q, d_q));
`else
  logic unused_qn;
  assign unused_qn = q1_n ^ q2_n;
  assign err       = 1'b0;
`endif

  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.rsp_err   = rsp_err_q;

  // Pins decode straight from state, so an async reset idles them at once.
  logic p_d, p_clk, p_pre_n, p_clr_n;

  always_comb begin
    p_d     = D_IDLE;
    p_clk   = CLK_IDLE;
    p_pre_n = PRE_N_IDLE;
    p_clr_n = CLR_N_IDLE;
    if (op_q == OP_LOAD &&
        (st == S_SETUP || st == S_PULSE || st == S_HOLD)) begin
      p_d = d_q;
    end
    if (st == S_PULSE) begin
      unique case (1'b1)
        op_q == OP_LOAD:   p_clk   = 1'b1;
        op_q == OP_PRESET: p_pre_n = 1'b0;
        op_q == OP_CLEAR:  p_clr_n = 1'b0;
        default: ;
      endcase
    end
    ff1_d     = D_IDLE;
    ff1_clk   = CLK_IDLE;
    ff1_pre_n = PRE_N_IDLE;
    ff1_clr_n = CLR_N_IDLE;
    ff2_d     = D_IDLE;
    ff2_clk   = CLK_IDLE;
    ff2_pre_n = PRE_N_IDLE;
    ff2_clr_n = CLR_N_IDLE;
    if (sel_q) begin
      ff2_d     = p_d;
      ff2_clk   = p_clk;
      ff2_pre_n = p_pre_n;
      ff2_clr_n = p_clr_n;
    end else begin
      ff1_d     = p_d;
      ff1_clk   = p_clk;
      ff1_pre_n = p_pre_n;
      ff1_clr_n = p_clr_n;
    end
  end

endmodule

// File: tb/tb_dff7474_ctrl.sv
// tb_dff7474_ctrl: directed bench for dff7474_ctrl with a behavioural
// SN7474 model on the pins and hand-computed expectations.
module tb_dff7474_ctrl;
  import dff7474_pkg::*;

`ifdef DFF7474_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [7:0] IDLE = 8'b1001_1001;

  logic clk = 1'b0;
  logic reset;
  logic ff1_clr_n, ff1_d, ff1_clk, ff1_pre_n;
  logic ff2_pre_n, ff2_clk, ff2_d, ff2_clr_n;
  logic q1, q1_n, q2, q2_n;
  logic m1 = 1'b0;
  logic m2 = 1'b0;
  logic bad = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int lat;
  logic [7:0] plog [0:31];
  logic [7:0] pins;

  dff7474_ctrl_if bus ();

  dff7474_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ff1_clr_n (ff1_clr_n),
    .ff1_d     (ff1_d),
    .ff1_clk   (ff1_clk),
    .ff1_pre_n (ff1_pre_n),
    .ff2_pre_n (ff2_pre_n),
    .ff2_clk   (ff2_clk),
    .ff2_d     (ff2_d),
    .ff2_clr_n (ff2_clr_n),
    .q1        (q1),
    .q1_n      (q1_n),
    .q2_n      (q2_n),
    .q2        (q2)
  );

  always #5 clk = ~clk;

  always @(posedge ff1_clk or negedge ff1_pre_n or negedge ff1_clr_n)
    if (!ff1_pre_n) m1 <= 1'b1;
    else if (!ff1_clr_n) m1 <= 1'b0;
    else m1 <= ff1_d;

  always @(posedge ff2_clk or negedge ff2_pre_n or negedge ff2_clr_n)
    if (!ff2_pre_n) m2 <= 1'b1;
    else if (!ff2_clr_n) m2 <= 1'b0;
    else m2 <= ff2_d;

  assign q1   = bad | m1;
  assign q1_n = bad | ~m1;
  assign q2   = m2;
  assign q2_n = ~m2;
  assign pins = {ff1_clr_n, ff1_d, ff1_clk, ff1_pre_n,
                 ff2_pre_n, ff2_clk, ff2_d, ff2_clr_n};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic id, input op_e op,
                        input logic sel, input logic d);
    int w;
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op;
      bus.req1_sel = sel; bus.req1_d = d;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op;
      bus.req0_sel = sel; bus.req0_d = d;
    end
    #1;
    w = 0;
    while (!(id ? bus.req1_ready : bus.req0_ready) && w < 40) begin
      @(negedge clk); #1; w++;
    end
    check("ready_seen", 32'(w < 40), 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 32; i++) plog[i] = IDLE;
    lat = 0;
    while (!bus.rsp_valid && lat < 30) begin
      plog[lat] = pins;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ng, nr, both, cnt;
    logic [3:0] gseq, rseq;
    logic anyd;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_op = OP_LOAD;
    bus.req0_sel = 1'b0; bus.req0_d = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_op = OP_LOAD;
    bus.req1_sel = 1'b0; bus.req1_d = 1'b0;
    repeat (2) @(negedge clk);
    bus.req0_valid = 1'b1;
    #1;
    check("rst_pins", pins, IDLE);
    check("rst_rdy0", bus.req0_ready, 0);
    check("rst_rdy1", bus.req1_ready, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_q, bus.rsp_err}, 0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Both requesters held valid: grants and responses alternate 0,1,0,1.
    @(negedge clk);
    bus.req0_op = OP_READ; bus.req0_sel = 1'b0;
    bus.req1_op = OP_READ; bus.req1_sel = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    ng = 0; nr = 0; both = 0; gseq = '0; rseq = '0;
    for (int i = 0; i < 40 && nr < 4; i++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) both++;
      if ((bus.req0_ready || bus.req1_ready) && ng < 4) begin
        gseq[ng] = bus.req1_ready; ng++;
      end
      if (bus.rsp_valid && nr < 4) begin
        rseq[nr] = bus.rsp_id; nr++;
      end
      if (nr == 4) begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("rr_grants", gseq, 4'b1010);
    check("rr_rsp_ids", rseq, 4'b1010);
    check("rr_nboth", both, 0);
    repeat (3) @(negedge clk);

    // LOAD ff1 d=1.
    run_op(1'b0, OP_LOAD, 1'b0, 1'b1);
    check("ld_lat", lat, 7);
    check("ld_id", bus.rsp_id, 0);
    check("ld_q", bus.rsp_q, 1);
    check("ld_err", bus.rsp_err, 0);
    check("ld_setup", plog[1], 8'b1101_1001);
    check("ld_pulse0", plog[2], 8'b1111_1001);
    check("ld_pulse1", plog[3], 8'b1111_1001);
    check("ld_hold", plog[4], 8'b1101_1001);
    check("ld_sample", plog[5], IDLE);
    @(negedge clk);
    check("ld_rsp_1cyc", bus.rsp_valid, 0);

    // LOAD ff2 d=1, then CLEAR ff2 from requester 1.
    run_op(1'b0, OP_LOAD, 1'b1, 1'b1);
    check("ld2_q", bus.rsp_q, 1);
    run_op(1'b1, OP_CLEAR, 1'b1, 1'b1);
    check("clr_lat", lat, 7);
    check("clr_id", bus.rsp_id, 1);
    check("clr_q", bus.rsp_q, 0);
    check("clr_setup", plog[1], IDLE);
    check("clr_pulse0", plog[2], 8'b1001_1000);
    check("clr_pulse1", plog[3], 8'b1001_1000);
    check("clr_hold", plog[4], IDLE);
    anyd = 1'b0;
    for (int i = 0; i < 7; i++) anyd |= plog[i][1];
    check("clr_d2_low", anyd, 0);

    // READ ff1: no pin activity, q1 is 1 from the first LOAD.
    run_op(1'b0, OP_READ, 1'b0, 1'b0);
    check("rd_lat", lat, 2);
    check("rd_q", bus.rsp_q, 1);
    check("rd_pins", {plog[0], plog[1]}, {IDLE, IDLE});

    // Reset in the middle of a LOAD d=0 pulse.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = OP_LOAD;
    bus.req0_sel = 1'b0; bus.req0_d = 1'b0;
    #1;
    check("mid_ready", bus.req0_ready, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_pulse", ff1_clk, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_clk0", ff1_clk, 0);
    check("mid_pins", pins, IDLE);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    check("mid_no_rsp", cnt, 0);
    run_op(1'b0, OP_READ, 1'b0, 1'b0);
    check("post_rst_lat", lat, 2);
    check("post_rst_q", bus.rsp_q, 0);

    // PRESET with Q and Qn both forced high, then a clean PRESET.
    bad = 1'b1;
    run_op(1'b0, OP_PRESET, 1'b0, 1'b0);
    bad = 1'b0;
    check("pre_bad_lat", lat, 7);
    check("pre_bad_err", bus.rsp_err, ERR_EN);
    check("pre_pulse", plog[2], 8'b1000_1001);
    run_op(1'b1, OP_PRESET, 1'b0, 1'b0);
    check("pre_q", bus.rsp_q, 1);
    check("pre_err", bus.rsp_err, 0);
    check("pre_id", bus.rsp_id, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
